spi_ram_arbiter: RTL and testbench
==================================

// Module: spi_ram_arbiter
// PURPOSE
//  Sits between the SPI slave and the single-port RAM and shares the RAM with a local host port.
//  Both requesters use the same 10-bit command format: [9:8] 00=wr addr, 01=wr data,
//  10=rd addr, 11=rd data; [7:0] payload.
//  Owns RAM ownership across address/data command pairs and routes read data back to the owner.
//  Buffers SPI commands, which cannot be stalled, in a small FIFO.
// PARAMETERS
//  FIFO_DEPTH  4   SPI command FIFO entries (power of 2, >=2)
//  RD_TIMEOUT  16  max cycles to wait for ram_tx_valid after issuing a cmd 11
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  spi_rx_data   in   10  command from SPI slave
//  spi_rx_valid  in   1   1-cycle strobe, spi_rx_data valid
//  spi_tx_data   out  8   read data to SPI slave
//  spi_tx_valid  out  1   1-cycle strobe, spi_tx_data valid
//  host_req      in   1   host command request; hold with host_cmd stable until host_gnt
//  host_cmd      in   10  host command
//  host_gnt      out  1   1-cycle strobe: host_cmd accepted this cycle
//  host_rdata    out  8   read data to host
//  host_rvalid   out  1   1-cycle strobe, host_rdata valid
//  ram_din       out  10  command to RAM
//  ram_rx_valid  out  1   1-cycle strobe, ram_din valid
//  ram_dout      in   8   RAM read data
//  ram_tx_valid  in   1   RAM read data strobe
//  spi_overflow  out  1   sticky: SPI cmd dropped because FIFO was full
//  rd_timeout    out  1   sticky: RD_TIMEOUT expired without ram_tx_valid
// BEHAVIOUR
//  - All outputs are registered. All outputs reset to 0. FSM resets to IDLE and the FIFO is emptied.
//  - Sticky flags clear only on reset.
//  - FIFO: spi_rx_valid pushes spi_rx_data.
//    - When full, a push is accepted only if a pop occurs in the same cycle.
//    - Otherwise the command is dropped and spi_overflow is set.
//  - FSM states: IDLE, SPI_OWN, HOST_OWN, RD_WAIT. Owner register = SPI or HOST.
//  - IDLE: a candidate is FIFO non-empty (SPI) or host_req (HOST).
//    - If both are candidates, the one that did not win last arbitration gets the grant.
//    - The last-winner register resets to HOST, so SPI wins the first tie.
//    - The winner's command is issued: ram_din/ram_rx_valid at cycle N+1 from the decision at N.
//    - SPI: FIFO pops at N. HOST: host_gnt pulses at N+1, coincident with ram_rx_valid.
//  - Issued cmd 00/10: enter <owner>_OWN (ownership lock).
//  - Issued cmd 01: return to IDLE (pair complete).
//  - Issued cmd 11: enter RD_WAIT.
//  - A data cmd issued from IDLE with no preceding address cmd is forwarded as a one-shot with the same rules.
//  - <owner>_OWN: only the owner's commands are issued, at most one per cycle, same timing as IDLE.
//    - Further 00/10 keep the lock. 01 -> IDLE. 11 -> RD_WAIT.
//    - Non-owner: SPI keeps queueing in the FIFO; host_gnt stays low.
//  - RD_WAIT: no commands are issued. A timeout counter starts at 0.
//    - ram_tx_valid: ram_dout goes to the owner's data port with a valid strobe 1 cycle later; -> IDLE.
//    - Counter reaches RD_TIMEOUT-1 with no response: set rd_timeout, -> IDLE, no data strobe.
//    - ram_tx_valid in the expiry cycle: the response wins and rd_timeout is not set.
//  - ram_tx_valid outside RD_WAIT is ignored. This covers late responses after timeout or reset.
//  - Reset mid-transaction: lock released, FIFO contents discarded, no strobes until a new command arrives.
//  - ram_rx_valid is never asserted for two sources in one cycle. At most one cmd per cycle reaches the RAM.
// TESTING
//  - SPI write pair 0x0A5, 0x13C:
//    -> ram_din 0x0A5 then 0x13C, each 1 cycle after its FIFO push.
//    -> FSM SPI_OWN then IDLE; no host_gnt.
//  - Host read pair 0x210, 0x300; RAM returns 0x5A 2 cycles after the 0x300 strobe:
//    -> host_rvalid with host_rdata=0x5A 1 cycle later; spi_tx_valid stays 0.
//  - Host 0x210 and an SPI push arrive in the same idle cycle after reset:
//    -> SPI wins.
//    -> Host cmd 0x210 is granted only after the SPI 01 completes.
//    -> The next tie goes to the host.
//  - During a host lock, push FIFO_DEPTH+1 SPI cmds:
//    -> spi_overflow=1.
//    -> The first 4 are issued in order after the lock releases; the 5th is never issued.
//  - SPI 0x2FF, 0x300 with no ram_tx_valid:
//    -> rd_timeout=1 after 16 cycles in RD_WAIT; FSM IDLE.
//    -> A later ram_tx_valid produces no spi_tx_valid.
//  - Assert rst_n=0 while in RD_WAIT:
//    -> All outputs 0, FIFO empty.
//    -> A subsequent host 0x100 is granted 1 cycle after host_req.

Source files
------------

// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the SPI slave, the local host, the RAM and the arbiter.
// The arbiter takes the slave modport; the surrounding environment takes the master modport.
interface spi_ram_arbiter_if;
  localparam int unsigned CMD_W = 10;
  localparam int unsigned DAT_W = 8;

  logic [CMD_W-1:0] spi_rx_data;
  logic             spi_rx_valid;
  logic [DAT_W-1:0] spi_tx_data;
  logic             spi_tx_valid;
  logic             host_req;
  logic [CMD_W-1:0] host_cmd;
  logic             host_gnt;
  logic [DAT_W-1:0] host_rdata;
  logic             host_rvalid;
  logic [CMD_W-1:0] ram_din;
  logic             ram_rx_valid;
  logic [DAT_W-1:0] ram_dout;
  logic             ram_tx_valid;
  logic             spi_overflow;
  logic             rd_timeout;

  modport slave (
    input  spi_rx_data, spi_rx_valid, host_req, host_cmd, ram_dout, ram_tx_valid,
    output spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_din, ram_rx_valid, spi_overflow, rd_timeout
  );

  modport master (
    output spi_rx_data, spi_rx_valid, host_req, host_cmd, ram_dout, ram_tx_valid,
    input  spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_din, ram_rx_valid, spi_overflow, rd_timeout
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between an unstallable SPI command stream (FIFO-buffered)
// and a req/gnt host port, holding ownership across address/data pairs and routing read data back.
module spi_ram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_arbiter_if.slave bus
);
  localparam int unsigned CMD_W   = 10;
  localparam int unsigned DAT_W   = 8;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PCNT_W  = PTR_W + 1;
  localparam int unsigned CNT_W   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [1:0]  OP_WR_DATA = 2'b01;
  localparam logic [1:0]  OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {IDLE, SPI_OWN, HOST_OWN, RD_WAIT} state_e;
  typedef enum logic {OWN_SPI = 1'b0, OWN_HOST = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [PCNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt;
  logic [CMD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [CMD_W-1:0]  mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [CMD_W-1:0]  ram_din_q, ram_din_d;
  logic              ram_rx_valid_q, ram_rx_valid_d;
  logic              host_gnt_q, host_gnt_d;
  logic [DAT_W-1:0]  spi_tx_data_q, spi_tx_data_d, host_rdata_q, host_rdata_d;
  logic              spi_tx_valid_q, spi_tx_valid_d, host_rvalid_q, host_rvalid_d;
  logic              spi_overflow_q, spi_overflow_d, rd_timeout_q, rd_timeout_d;

  logic              fifo_empty, fifo_full, spi_cand, host_cand;
  logic              issue_spi, issue_host, spi_push;
  logic [CMD_W-1:0]  spi_head, issue_cmd;

  // An empty FIFO is bypassed so a fresh SPI strobe can be arbitrated in its own cycle
  always_comb begin
    fifo_cnt   = wr_ptr_q - rd_ptr_q;
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == PCNT_W'(FIFO_DEPTH));
    spi_head   = fifo_empty ? bus.spi_rx_data : mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    mem_d          = mem_q;
    tmo_d          = '0;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    host_gnt_d     = 1'b0;
    spi_tx_data_d  = spi_tx_data_q;
    spi_tx_valid_d = 1'b0;
    host_rdata_d   = host_rdata_q;
    host_rvalid_d  = 1'b0;
    spi_overflow_d = spi_overflow_q;
    rd_timeout_d   = rd_timeout_q;
    issue_spi      = 1'b0;
    issue_host     = 1'b0;
    issue_cmd      = '0;
    spi_cand       = !fifo_empty || bus.spi_rx_valid;
    // A host command granted last cycle is still on the bus; do not take it twice
    host_cand      = bus.host_req && !host_gnt_q;

    case (state_q)
      IDLE: begin
        if (spi_cand && host_cand) begin
          issue_spi  = (last_q == OWN_HOST);
          issue_host = !issue_spi;
          last_d     = issue_spi ? OWN_SPI : OWN_HOST;
        end else begin
          issue_spi  = spi_cand;
          issue_host = host_cand;
        end
      end
      SPI_OWN:  issue_spi  = spi_cand;
      HOST_OWN: issue_host = host_cand;
      RD_WAIT: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (bus.ram_tx_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_HOST) begin
            host_rdata_d  = bus.ram_dout;
            host_rvalid_d = 1'b1;
          end else begin
            spi_tx_data_d  = bus.ram_dout;
            spi_tx_valid_d = 1'b1;
          end
        end else if (tmo_q == CNT_W'(RD_TIMEOUT - 1)) begin
          rd_timeout_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_spi || issue_host) begin
      issue_cmd      = issue_spi ? spi_head : bus.host_cmd;
      owner_d        = issue_spi ? OWN_SPI : OWN_HOST;
      ram_din_d      = issue_cmd;
      ram_rx_valid_d = 1'b1;
      host_gnt_d     = issue_host;
      case (issue_cmd[9:8])
        OP_WR_DATA: state_d = IDLE;
        OP_RD_DATA: state_d = RD_WAIT;
        default:    state_d = issue_spi ? SPI_OWN : HOST_OWN;
      endcase
    end

    // A full FIFO still accepts a push when its head leaves in the same cycle
    spi_push = bus.spi_rx_valid && (!fifo_full || issue_spi);
    if (spi_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = bus.spi_rx_data;
      wr_ptr_d = wr_ptr_q + PCNT_W'(1);
    end
    if (issue_spi) rd_ptr_d = rd_ptr_q + PCNT_W'(1);
    if (bus.spi_rx_valid && !spi_push) spi_overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_SPI;
      last_q         <= OWN_HOST;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      mem_q          <= '{default: '0};
      tmo_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      host_gnt_q     <= 1'b0;
      spi_tx_data_q  <= '0;
      spi_tx_valid_q <= 1'b0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      spi_overflow_q <= 1'b0;
      rd_timeout_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      tmo_q          <= tmo_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      host_gnt_q     <= host_gnt_d;
      spi_tx_data_q  <= spi_tx_data_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      spi_overflow_q <= spi_overflow_d;
      rd_timeout_q   <= rd_timeout_d;
    end
  end

  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;
  assign bus.host_gnt     = host_gnt_q;
  assign bus.spi_tx_data  = spi_tx_data_q;
  assign bus.spi_tx_valid = spi_tx_valid_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.spi_overflow = spi_overflow_q;
  assign bus.rd_timeout   = rd_timeout_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scenario bench for spi_ram_arbiter: RAM commands and read data are scoreboarded
// against queues filled as stimulus is driven; each scenario task adds its own timing checks.
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_arbiter_if bus ();
  spi_ram_arbiter #(.FIFO_DEPTH(4), .RD_TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_ram[$];
  logic [8:0] exp_rd[$];   // {to_host, data}
  logic [9:0] mon_ram;
  logic [8:0] mon_rd;

  // Scoreboard monitor: every RAM command and every read-data strobe must be expected
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (bus.ram_rx_valid === 1'b1) begin
        checks++;
        if (exp_ram.size() == 0) begin
          errors++;
          $display("FAIL ram_cmd_unexpected got=%h", bus.ram_din);
        end else begin
          mon_ram = exp_ram.pop_front();
          if (bus.ram_din !== mon_ram) begin
            errors++;
            $display("FAIL ram_cmd got=%h exp=%h", bus.ram_din, mon_ram);
          end
        end
      end
      if (bus.spi_tx_valid === 1'b1 || bus.host_rvalid === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0 || (bus.spi_tx_valid === 1'b1 && bus.host_rvalid === 1'b1)) begin
          errors++;
          $display("FAIL rd_data_unexpected spi_v=%b host_v=%b", bus.spi_tx_valid, bus.host_rvalid);
        end else begin
          mon_rd = exp_rd.pop_front();
          if ({bus.host_rvalid, (bus.host_rvalid ? bus.host_rdata : bus.spi_tx_data)} !== mon_rd) begin
            errors++;
            $display("FAIL rd_data got={host:%b,%h} exp={host:%b,%h}", bus.host_rvalid,
                     bus.host_rvalid ? bus.host_rdata : bus.spi_tx_data, mon_rd[8], mon_rd[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.spi_rx_data  = '0;
    bus.spi_rx_valid = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_cmd     = '0;
    bus.ram_dout     = '0;
    bus.ram_tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Hold a host request until granted; waited = cycles to grant, -1 if never granted
  task automatic host_issue(input logic [9:0] cmd, output int waited);
    bus.host_req = 1'b1;
    bus.host_cmd = cmd;
    waited = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.host_gnt === 1'b1) begin
        waited = i;
        break;
      end
    end
    bus.host_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    outs = {bus.spi_tx_data, bus.spi_tx_valid, bus.host_gnt, bus.host_rdata, bus.host_rvalid,
            bus.ram_din, bus.ram_rx_valid, bus.spi_overflow, bus.rd_timeout};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=00000000", outs);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_write();
    exp_ram.push_back(10'h0A5);
    exp_ram.push_back(10'h13C);
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h0A5;
    tick();
    checks++;
    if (bus.ram_rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL spi_wr_addr_latency got=%b exp=1", bus.ram_rx_valid);
    end
    bus.spi_rx_data = 10'h13C;
    tick();
    bus.spi_rx_valid = 1'b0;
    checks++;
    if ({bus.ram_rx_valid, bus.host_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL spi_wr_data_latency got={v:%b,gnt:%b} exp={v:1,gnt:0}", bus.ram_rx_valid, bus.host_gnt);
    end
    tick();
  endtask

  task automatic test_host_read();
    int w;
    exp_ram.push_back(10'h210);
    exp_ram.push_back(10'h300);
    exp_rd.push_back({1'b1, 8'h5A});
    host_issue(10'h210, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL host_rd_addr_gnt got=%0d exp=1", w);
    end
    host_issue(10'h300, w);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL host_rd_data_gnt got=%0d exp=2", w);
    end
    tick();
    tick();
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'h5A;
    tick();
    bus.ram_tx_valid = 1'b0;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata, bus.spi_tx_valid} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL host_rdata got={v:%b,d:%h,spi_v:%b} exp={v:1,d:5a,spi_v:0}",
               bus.host_rvalid, bus.host_rdata, bus.spi_tx_valid);
    end
    tick();
  endtask

  task automatic test_tie();
    int w;
    int gnts;
    exp_ram.push_back(10'h011);
    exp_ram.push_back(10'h122);
    exp_ram.push_back(10'h210);
    exp_ram.push_back(10'h300);
    exp_ram.push_back(10'h1DD);
    exp_ram.push_back(10'h0CC);
    exp_ram.push_back(10'h1EE);
    exp_rd.push_back({1'b1, 8'h77});
    bus.host_req = 1'b1;
    bus.host_cmd = 10'h210;
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h011;
    tick();
    bus.spi_rx_valid = 1'b0;
    checks++;
    if ({bus.ram_rx_valid, bus.ram_din, bus.host_gnt} !== {1'b1, 10'h011, 1'b0}) begin
      errors++;
      $display("FAIL tie1_spi_wins got={v:%b,d:%h,gnt:%b} exp={v:1,d:011,gnt:0}",
               bus.ram_rx_valid, bus.ram_din, bus.host_gnt);
    end
    gnts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.host_gnt === 1'b1) gnts++;
    end
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h122;
    tick();
    bus.spi_rx_valid = 1'b0;
    if (bus.host_gnt === 1'b1) gnts++;
    checks++;
    if (gnts !== 0) begin
      errors++;
      $display("FAIL tie1_host_locked_out got=%0d grants exp=0", gnts);
    end
    tick();
    checks++;
    if ({bus.host_gnt, bus.ram_din} !== {1'b1, 10'h210}) begin
      errors++;
      $display("FAIL tie1_host_after_pair got={gnt:%b,d:%h} exp={gnt:1,d:210}", bus.host_gnt, bus.ram_din);
    end
    host_issue(10'h300, w);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL tie1_host_rd_data_gnt got=%0d exp=2", w);
    end
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'h77;
    tick();
    bus.ram_tx_valid = 1'b0;
    bus.host_req = 1'b1;
    bus.host_cmd = 10'h1DD;
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h0CC;
    tick();
    bus.host_req = 1'b0;
    bus.spi_rx_valid = 1'b0;
    checks++;
    if ({bus.host_gnt, bus.ram_din} !== {1'b1, 10'h1DD}) begin
      errors++;
      $display("FAIL tie2_host_wins got={gnt:%b,d:%h} exp={gnt:1,d:1dd}", bus.host_gnt, bus.ram_din);
    end
    tick();
    checks++;
    if ({bus.ram_rx_valid, bus.ram_din} !== {1'b1, 10'h0CC}) begin
      errors++;
      $display("FAIL tie2_spi_queued got={v:%b,d:%h} exp={v:1,d:0cc}", bus.ram_rx_valid, bus.ram_din);
    end
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h1EE;
    tick();
    bus.spi_rx_valid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int w;
    int strobes;
    logic [9:0] cmds [5];
    cmds[0] = 10'h001; cmds[1] = 10'h102; cmds[2] = 10'h003; cmds[3] = 10'h104; cmds[4] = 10'h005;
    exp_ram.push_back(10'h0AB);
    exp_ram.push_back(10'h1CD);
    for (int i = 0; i < 4; i++) exp_ram.push_back(cmds[i]);
    host_issue(10'h0AB, w);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++;
        if (bus.spi_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got=%b exp=0", bus.spi_overflow);
        end
      end
      bus.spi_rx_valid = 1'b1;
      bus.spi_rx_data  = cmds[i];
      tick();
    end
    bus.spi_rx_valid = 1'b0;
    checks++;
    if (bus.spi_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%b exp=1", bus.spi_overflow);
    end
    host_issue(10'h1CD, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL ovf_host_release_gnt got=%0d exp=1", w);
    end
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ram_rx_valid === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 4 || bus.spi_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain got={n:%0d,ovf:%b} exp={n:4,ovf:1}", strobes, bus.spi_overflow);
    end
  endtask

  task automatic test_timeout();
    int w;
    int bad;
    exp_ram.push_back(10'h2FF);
    exp_ram.push_back(10'h300);
    exp_ram.push_back(10'h1AA);
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h2FF;
    tick();
    bus.spi_rx_data  = 10'h300;
    tick();
    bus.spi_rx_valid = 1'b0;
    checks++;
    if ({bus.ram_rx_valid, bus.ram_din} !== {1'b1, 10'h300}) begin
      errors++;
      $display("FAIL tmo_rd_issue got={v:%b,d:%h} exp={v:1,d:300}", bus.ram_rx_valid, bus.ram_din);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (bus.rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=0", bus.rd_timeout);
    end
    tick();
    checks++;
    if (bus.rd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set got=%b exp=1", bus.rd_timeout);
    end
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'hAB;
    bad = 0;
    tick();
    bus.ram_tx_valid = 1'b0;
    if (bus.spi_tx_valid === 1'b1) bad++;
    tick();
    if (bus.spi_tx_valid === 1'b1) bad++;
    checks++;
    if (bad !== 0 || bus.rd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_late_resp got={strobes:%0d,tmo:%b} exp={strobes:0,tmo:1}", bad, bus.rd_timeout);
    end
    host_issue(10'h1AA, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL tmo_back_to_idle got=%0d exp=1", w);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int w;
    int strobes;
    logic [31:0] outs;
    exp_ram.push_back(10'h210);
    exp_ram.push_back(10'h300);
    host_issue(10'h210, w);
    host_issue(10'h300, w);
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = 10'h0EE;
    tick();
    bus.spi_rx_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    outs = {bus.spi_tx_data, bus.spi_tx_valid, bus.host_gnt, bus.host_rdata, bus.host_rvalid,
            bus.ram_din, bus.ram_rx_valid, bus.spi_overflow, bus.rd_timeout};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h exp=00000000", outs);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'h99;
    tick();
    bus.ram_tx_valid = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.ram_rx_valid === 1'b1 || bus.host_rvalid === 1'b1 || bus.spi_tx_valid === 1'b1) strobes++;
      tick();
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet got=%0d strobes exp=0", strobes);
    end
    exp_ram.push_back(10'h100);
    host_issue(10'h100, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL mid_reset_host_gnt got=%0d exp=1", w);
    end
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spi_write();
    test_host_read();
    do_reset();
    test_tie();
    test_overflow();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_ram.size() !== 0 || exp_rd.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got={ram:%0d,rd:%0d} exp={ram:0,rd:0}", exp_ram.size(), exp_rd.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
